// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit for a 5-stage RV32I pipeline.
// Issues req/ack data-bus cycles, stalls while busy, returns extended load data and error strobes.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        memWrite_MEM_IN,
    input  logic        memRead_MEM_IN,
    input  logic [2:0]  func3_MEM_IN,
    input  logic [31:0] aluOut_MEM_IN,
    input  logic [31:0] aluSrc2_MEM_IN,
    output logic        dmem_req_Out,
    output logic        dmem_we_Out,
    output logic [31:0] dmem_addr_Out,
    output logic [31:0] dmem_wdata_Out,
    output logic [3:0]  dmem_be_Out,
    input  logic [31:0] dmem_rdata_IN,
    input  logic        dmem_ack_IN,
    output logic        stall_MEM_Out,
    output logic [31:0] loadData_MEM_Out,
    output logic        loadValid_MEM_Out,
    output logic        misaligned_MEM_Out,
    output logic        busErr_MEM_Out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_r;
    logic              we_r;
    logic [31:0]       addr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        be_r;
    logic [2:0]        func3_r;
    logic [1:0]        off_r;
    logic [31:0]       load_data_r;
    logic              load_valid_r;
    logic              misaligned_r;
    logic              bus_err_r;

    logic              access_s;
    logic              both_s;
    logic              legal_f3_s;
    logic              unaligned_s;
    logic              illegal_s;
    logic              misaligned_s;
    logic              start_s;
    logic              stall_s;

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
        case (size)
            2'b00:   return {4{rs2[7:0]}};
            2'b01:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    // Byte lane o is shifted down to bit 0 first, so all sub-word loads extract from the bottom.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    // Decode the EX/MEM request into start / misaligned / illegal.
    always_comb begin
        access_s = memRead_MEM_IN ^ memWrite_MEM_IN;
        both_s   = memRead_MEM_IN & memWrite_MEM_IN;
        if (memWrite_MEM_IN) begin
            legal_f3_s = (func3_MEM_IN == 3'b000) || (func3_MEM_IN == 3'b001) ||
                         (func3_MEM_IN == 3'b010);
        end else begin
            legal_f3_s = (func3_MEM_IN == 3'b000) || (func3_MEM_IN == 3'b001) ||
                         (func3_MEM_IN == 3'b010) || (func3_MEM_IN == 3'b100) ||
                         (func3_MEM_IN == 3'b101);
        end
        if (func3_MEM_IN[1:0] == 2'b01) begin
            unaligned_s = aluOut_MEM_IN[0];
        end else if (func3_MEM_IN[1:0] == 2'b10) begin
            unaligned_s = (aluOut_MEM_IN[1:0] != 2'b00);
        end else begin
            unaligned_s = 1'b0;
        end
        illegal_s    = both_s | (access_s & ~legal_f3_s);
        misaligned_s = access_s & legal_f3_s & unaligned_s;
        start_s      = access_s & legal_f3_s & ~unaligned_s;
    end

    // Stall is combinational in IDLE so the instruction is frozen in the cycle it is accepted.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = start_s & rstN;
            ST_BUSY: stall_s = 1'b1;
            default: stall_s = 1'b0;
        endcase
    end

    // Access FSM with registered bus outputs, load result and strobes.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            be_r         <= 4'b0000;
            func3_r      <= 3'b000;
            off_r        <= 2'b00;
            load_data_r  <= 32'd0;
            load_valid_r <= 1'b0;
            misaligned_r <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            load_valid_r <= 1'b0;
            misaligned_r <= 1'b0;
            bus_err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (start_s) begin
                        req_r   <= 1'b1;
                        we_r    <= memWrite_MEM_IN;
                        addr_r  <= {aluOut_MEM_IN[31:2], 2'b00};
                        be_r    <= memWrite_MEM_IN ?
                                   store_be(func3_MEM_IN[1:0], aluOut_MEM_IN[1:0]) : 4'b0000;
                        wdata_r <= memWrite_MEM_IN ?
                                   store_wdata(func3_MEM_IN[1:0], aluSrc2_MEM_IN) : 32'd0;
                        func3_r <= func3_MEM_IN;
                        off_r   <= aluOut_MEM_IN[1:0];
                        state_r <= ST_BUSY;
                    end else if (misaligned_s) begin
                        misaligned_r <= 1'b1;
                    end else if (illegal_s) begin
                        bus_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack_IN) begin
                        req_r        <= 1'b0;
                        load_valid_r <= ~we_r;
                        if (!we_r) begin
                            load_data_r <= load_extend(func3_r, off_r, dmem_rdata_IN);
                        end
                        state_r <= ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        req_r        <= 1'b0;
                        bus_err_r    <= 1'b1;
                        load_valid_r <= ~we_r;
                        if (!we_r) begin
                            load_data_r <= 32'd0;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign dmem_req_Out       = req_r;
    assign dmem_we_Out        = we_r;
    assign dmem_addr_Out      = addr_r;
    assign dmem_wdata_Out     = wdata_r;
    assign dmem_be_Out        = be_r;
    assign stall_MEM_Out      = stall_s;
    assign loadData_MEM_Out   = load_data_r;
    assign loadValid_MEM_Out  = load_valid_r;
    assign misaligned_MEM_Out = misaligned_r;
    assign busErr_MEM_Out     = bus_err_r;

endmodule
